assist_sequencer: RTL and testbench

- Sequences the motor assistance command between the assistance calculator and the current-control module.
- Gates assistance on rider enable, pedalling activity (cadence timeout), brake and bike tilt.
- Slew-limits the command on a fixed tick.
- Latches a tilt fault, which clears only after a hold-off.

---
 rtl/assist_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_assist_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/assist_sequencer.sv
// assist_sequencer
//   Sequences the motor assistance command between the assistance calculator
//   and current control. Assistance is gated on rider enable, pedalling
//   activity (cadence timeout), brake and bike tilt. The command is
//   slew-limited on a fixed tick. A tilt fault is latched and clears only
//   after a clean hold-off with pedalling stopped.
//
//   Optional build macro: ASSIST_SEQ_FAULT_COUNT_EN adds fault_count_o, a
//   saturating count of entries into FAULT (cleared only by reset).
//
// Ports
//   clk_i             system clock
//   reset_i           asynchronous, active-high reset
//   assist_req_i      [12:0] unsigned requested assistance
//   resolved_roll_i   [9:0]  signed roll from the IMU
//   cadence_i         raw pedal sensor (asynchronous)
//   brake_i           brake lever, active high
//   enable_i          rider assist enable
//   assist_cmd_o      [12:0] slew-limited command (registered)
//   seq_state_o       [1:0]  0=IDLE 1=ACTIVE 2=DECAY 3=FAULT
//   fault_o           high while in FAULT
//   cadence_active_o  pedalling detected
//   fault_count_o     [7:0]  FAULT entry count (macro builds only)
module assist_sequencer #(
  parameter int TICK_DIV        = 50000,
  parameter int RAMP_UP_STEP    = 16,
  parameter int RAMP_DN_STEP    = 64,
  parameter int CADENCE_TIMEOUT = 500,
  parameter int ROLL_LIMIT      = 45,
  parameter int FAULT_HOLD      = 1000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [12:0] assist_req_i,
  input  logic [9:0]  resolved_roll_i,
  input  logic        cadence_i,
  input  logic        brake_i,
  input  logic        enable_i,
  output logic [12:0] assist_cmd_o,
  output logic [1:0]  seq_state_o,
  output logic        fault_o,
  output logic        cadence_active_o
`ifdef ASSIST_SEQ_FAULT_COUNT_EN
  ,
  output logic [7:0]  fault_count_o
`endif
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(CADENCE_TIMEOUT + 1);
  localparam int HW = $clog2(FAULT_HOLD + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DECAY  = 2'd2,
    S_FAULT  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [12:0]   cmd_q, cmd_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] tick_cnt_q;
  logic          tick;
  logic          cad_s1_q, cad_s2_q, cad_s3_q;
  logic          cad_edge;
  logic [CW-1:0] cad_cnt_q, cad_cnt_d;
  logic          cad_act_q, cad_act_d;
  logic [9:0]    roll_mag;
  logic          tilt;
  logic          run;
  logic [13:0]   up_sum;
  logic [12:0]   up_cmd, dec_cmd, dn_cmd;

  // Free-running tick; strobe is the last count before wrap.
  assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)   tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= '0;
    else           tick_cnt_q <= tick_cnt_q + TW'(1);
  end

  // Cadence: two-flop synchroniser plus one history flop for edge detect.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cad_s1_q <= 1'b0;
      cad_s2_q <= 1'b0;
      cad_s3_q <= 1'b0;
    end else begin
      cad_s1_q <= cadence_i;
      cad_s2_q <= cad_s1_q;
      cad_s3_q <= cad_s2_q;
    end
  end

  assign cad_edge = cad_s2_q & ~cad_s3_q;

  // Edge wins over a same-cycle tick; activity drops once the count saturates.
  always_comb begin
    cad_cnt_d = cad_cnt_q;
    cad_act_d = cad_act_q;
    if (cad_edge) begin
      cad_cnt_d = '0;
      cad_act_d = 1'b1;
    end else begin
      if (tick && (cad_cnt_q != CW'(CADENCE_TIMEOUT))) cad_cnt_d = cad_cnt_q + CW'(1);
      if (cad_cnt_d == CW'(CADENCE_TIMEOUT)) cad_act_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cad_cnt_q <= '0;
      cad_act_q <= 1'b0;
    end else begin
      cad_cnt_q <= cad_cnt_d;
      cad_act_q <= cad_act_d;
    end
  end

  // |roll|, with the single unrepresentable -512 clamped to 511.
  always_comb begin
    if (!resolved_roll_i[9])              roll_mag = resolved_roll_i;
    else if (resolved_roll_i == 10'h200) roll_mag = 10'd511;
    else                                  roll_mag = ~resolved_roll_i + 10'd1;
  end

  assign tilt = (roll_mag >= 10'(ROLL_LIMIT));
  assign run  = enable_i & cad_act_q;

  // Slew candidates; the 14-bit sum keeps the up-step from wrapping past 8191.
  always_comb begin
    up_sum  = {1'b0, cmd_q} + 14'(RAMP_UP_STEP);
    up_cmd  = (up_sum > {1'b0, assist_req_i}) ? assist_req_i : up_sum[12:0];
    dec_cmd = (cmd_q >= 13'(RAMP_DN_STEP)) ? (cmd_q - 13'(RAMP_DN_STEP)) : 13'd0;
    dn_cmd  = (dec_cmd < assist_req_i) ? assist_req_i : dec_cmd;
  end

  // Priority: tilt, then FAULT hold-off, then brake, then run conditions.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    hold_d  = hold_q;
    if (tilt) begin
      state_d = S_FAULT;
      cmd_d   = '0;
      hold_d  = '0;
    end else if (state_q == S_FAULT) begin
      cmd_d = '0;
      if (tick && (hold_q != HW'(FAULT_HOLD))) hold_d = hold_q + HW'(1);
      if ((hold_q == HW'(FAULT_HOLD)) && !cad_act_q) begin
        state_d = S_IDLE;
        hold_d  = '0;
      end
    end else if (brake_i) begin
      state_d = S_IDLE;
      cmd_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cmd_d = '0;
          if (run) state_d = S_ACTIVE;
        end
        S_ACTIVE: begin
          if (!run) state_d = S_DECAY;
          else if (tick) begin
            if (assist_req_i > cmd_q)      cmd_d = up_cmd;
            else if (assist_req_i < cmd_q) cmd_d = dn_cmd;
          end
        end
        S_DECAY: begin
          if (run)                state_d = S_ACTIVE;
          else if (cmd_q == '0)   state_d = S_IDLE;
          else if (tick)          cmd_d   = dec_cmd;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      hold_q  <= hold_d;
    end
  end

`ifdef ASSIST_SEQ_FAULT_COUNT_EN
  logic [7:0] fcnt_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) fcnt_q <= '0;
    else if ((state_d == S_FAULT) && (state_q != S_FAULT) && (fcnt_q != 8'hFF))
      fcnt_q <= fcnt_q + 8'd1;
  end

  assign fault_count_o = fcnt_q;
`endif

  assign assist_cmd_o     = cmd_q;
  assign seq_state_o      = state_q;
  assign fault_o          = (state_q == S_FAULT);
  assign cadence_active_o = cad_act_q;

endmodule

// File: tb/tb_assist_sequencer.sv
module tb_assist_sequencer;
  localparam int TICK_DIV = 4;
  localparam int UP       = 16;
  localparam int DN       = 64;
  localparam int CAD_TO   = 8;
  localparam int ROLL_LIM = 45;
  localparam int HOLD     = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] req;
  logic [9:0]  roll;
  logic        cadence;
  logic        brake;
  logic        enable;
  logic [12:0] cmd;
  logic [1:0]  state;
  logic        fault;
  logic        cadact;
`ifdef ASSIST_SEQ_FAULT_COUNT_EN
  logic [7:0]  fcount;
`endif

  always #5 clk = ~clk;

  assist_sequencer #(
    .TICK_DIV(TICK_DIV), .RAMP_UP_STEP(UP), .RAMP_DN_STEP(DN),
    .CADENCE_TIMEOUT(CAD_TO), .ROLL_LIMIT(ROLL_LIM), .FAULT_HOLD(HOLD)
  ) dut (
    .clk_i(clk), .reset_i(rst), .assist_req_i(req), .resolved_roll_i(roll),
    .cadence_i(cadence), .brake_i(brake), .enable_i(enable),
    .assist_cmd_o(cmd), .seq_state_o(state), .fault_o(fault),
    .cadence_active_o(cadact)
`ifdef ASSIST_SEQ_FAULT_COUNT_EN
    , .fault_count_o(fcount)
`endif
  );

  // ---------------- behavioural model ----------------
  // State as small ints, command as plain integer arithmetic. Cadence
  // activity = "an edge has been seen and fewer than CAD_TO ticks since".
  int       m_state = 0, m_cmd = 0, m_hold = 0, m_since = 0, m_tcnt = 0, m_fcnt = 0;
  bit       m_seen = 0;
  bit [2:0] m_sync = '0;
  int       n_state, n_cmd, n_hold, mr, mag;
  bit       mk, me, mact, mtilt, mrun;

  function automatic int toward(input int cur, input int tgt);
    if (tgt > cur) return (cur + UP < tgt) ? cur + UP : tgt;
    if (tgt < cur) return (cur - DN > tgt) ? cur - DN : tgt;
    return cur;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_state = 0; m_cmd = 0; m_hold = 0; m_since = 0; m_tcnt = 0;
      m_fcnt = 0; m_seen = 0; m_sync = '0;
    end else begin
      mk    = (m_tcnt == TICK_DIV - 1);
      me    = m_sync[1] && !m_sync[2];
      mact  = m_seen && (m_since < CAD_TO);
      mr    = int'($signed(roll));
      mag   = (mr < 0) ? -mr : mr;
      if (mag > 511) mag = 511;
      mtilt = (mag >= ROLL_LIM);
      mrun  = enable && mact;
      n_state = m_state; n_cmd = m_cmd; n_hold = m_hold;
      if (mtilt) begin
        n_state = 3; n_cmd = 0; n_hold = 0;
      end else if (m_state == 3) begin
        if (mk) n_hold = (m_hold + 1 > HOLD) ? HOLD : m_hold + 1;
        if (m_hold == HOLD && !mact) begin n_state = 0; n_hold = 0; end
      end else if (brake) begin
        n_state = 0; n_cmd = 0;
      end else if (m_state == 0) begin
        if (mrun) n_state = 1;
      end else if (m_state == 1) begin
        if (!mrun) n_state = 2;
        else if (mk) n_cmd = toward(m_cmd, int'(req));
      end else begin
        if (mrun) n_state = 1;
        else if (m_cmd == 0) n_state = 0;
        else if (mk) n_cmd = (m_cmd > DN) ? m_cmd - DN : 0;
      end
      if (n_state == 3 && m_state != 3 && m_fcnt < 255) m_fcnt++;
      if (me) begin m_seen = 1; m_since = 0; end
      else if (mk && m_since < CAD_TO) m_since++;
      m_sync  = {m_sync[1:0], cadence};
      m_tcnt  = (m_tcnt + 1) % TICK_DIV;
      m_state = n_state; m_cmd = n_cmd; m_hold = n_hold;
    end
  end

  // ---------------- cadence generator ----------------
  bit cad_run = 0;
  int cad_per = 8;
  int cad_ph  = 0;

  initial begin
    cadence = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (cad_run) begin
        cad_ph  = (cad_ph >= cad_per - 1) ? 0 : cad_ph + 1;
        cadence = (cad_ph < cad_per / 2);
      end else cadence = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checks and stimulus ----------------
  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic wait_cmd(input int v, input int lim, input string nm);
    for (int i = 0; i < lim; i++) begin step(1); if (int'(cmd) == v) break; end
    chk(nm, int'(cmd), v);
  endtask

  task automatic wait_state(input int s, input int lim, input string nm);
    for (int i = 0; i < lim; i++) begin step(1); if (int'(state) == s) break; end
    chk(nm, int'(state), s);
  endtask

  task automatic wait_change(input int prev, input int exp, input string nm);
    for (int i = 0; i < 200; i++) begin step(1); if (int'(cmd) != prev) break; end
    chk(nm, int'(cmd), exp);
  endtask

  task automatic set_roll(input int v);
    roll = v[9:0];
  endtask

  int ramp_exp[7] = '{16, 32, 48, 64, 80, 96, 100};
  int prev, r, v;

  initial begin
    rst = 1'b1; enable = 1'b0; brake = 1'b0; req = '0; roll = '0;
    fork
      forever begin
        @(negedge clk);
        n_cmp++;
        if (int'(cmd) != m_cmd || int'(state) != m_state || fault != (m_state == 3) ||
            cadact != (m_seen && m_since < CAD_TO)) begin
          n_err++;
          $display("FAIL model t=%0t: cmd/state/fault/cad got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                   $time, cmd, state, fault, cadact, m_cmd, m_state, m_state == 3,
                   m_seen && m_since < CAD_TO);
        end
`ifdef ASSIST_SEQ_FAULT_COUNT_EN
        chk("model_fault_count", int'(fcount), m_fcnt);
`endif
      end
    join_none

    step(3);
    chk("reset_cmd", int'(cmd), 0);
    chk("reset_state", int'(state), 0);
    chk("reset_fault", int'(fault), 0);
    chk("reset_cadact", int'(cadact), 0);
    rst = 1'b0;

    // 1. ramp up to 100 and hold
    enable = 1'b1; req = 13'd100; cad_run = 1;
    wait_state(1, 200, "t1_active");
    prev = 0;
    foreach (ramp_exp[i]) begin
      wait_change(prev, ramp_exp[i], "t1_ramp");
      prev = int'(cmd);
    end
    step(20);
    chk("t1_hold", int'(cmd), 100);

    // 2. one-cycle brake cut, then re-ramp from 0
    brake = 1'b1; step(1); brake = 1'b0;
    chk("t2_brake_cmd", int'(cmd), 0);
    chk("t2_brake_state", int'(state), 0);
    wait_change(0, 16, "t2_reramp");

    // 3. cadence loss decay, then resume from 72
    req = 13'd200;
    wait_cmd(200, 400, "t3_reach200");
    cad_run = 0;
    wait_change(200, 136, "t3_dec136");
    chk("t3_decay_state", int'(state), 2);
    wait_change(136, 72, "t3_dec72");
    wait_change(72, 8, "t3_dec8");
    wait_change(8, 0, "t3_dec0");
    step(1);
    chk("t3_idle", int'(state), 0);
    cad_run = 1;
    wait_state(1, 200, "t3_reactive");
    wait_cmd(200, 400, "t3_reach200b");
    enable = 1'b0; step(1);
    chk("t3_dis_decay", int'(state), 2);
    wait_cmd(72, 200, "t3_at72");
    enable = 1'b1; step(1);
    chk("t3_resume_state", int'(state), 1);
    chk("t3_resume_cmd", int'(cmd), 72);
    wait_change(72, 88, "t3_resume_step");

    // 4. tilt fault, hold-off restart, exit; -512 also faults
    set_roll(-45); step(1);
    chk("t4_fault_state", int'(state), 3);
    chk("t4_fault_flag", int'(fault), 1);
    chk("t4_fault_cmd", int'(cmd), 0);
    cad_run = 0;
    set_roll(10); step(12);
    set_roll(50); step(1);
    set_roll(10); step(15);
    chk("t4_hold_restart", int'(state), 3);
    wait_state(0, 200, "t4_exit");
    chk("t4_exit_fault", int'(fault), 0);
    set_roll(-512); step(1);
    chk("t4_m512", int'(state), 3);
    set_roll(0);
    wait_state(0, 200, "t4_m512_exit");
    set_roll(-100); step(1);
    chk("t4_third", int'(state), 3);
    set_roll(0);
    wait_state(0, 200, "t4_third_exit");
`ifdef ASSIST_SEQ_FAULT_COUNT_EN
    chk("t6_fault_count3", int'(fcount), 3);
`endif

    // 5. saturation at 8191 and down-slew to a lower request
    cad_run = 1; req = 13'd8180;
    wait_state(1, 200, "t5_active");
    wait_cmd(8180, 3000, "t5_reach8180");
    req = 13'd8191;
    wait_change(8180, 8191, "t5_sat");
    step(20);
    chk("t5_sat_hold", int'(cmd), 8191);
    req = 13'd100;
    wait_cmd(100, 1000, "t5_down100");
    req = 13'd0;
    wait_change(100, 36, "t5_dn36");
    wait_change(36, 0, "t5_dn0");

    // 6. asynchronous reset mid-ramp
    req = 13'd100;
    wait_cmd(48, 200, "t6_at48");
    #2 rst = 1'b1;
    #1;
    chk("t6_async_cmd", int'(cmd), 0);
    chk("t6_async_state", int'(state), 0);
    chk("t6_async_cad", int'(cadact), 0);
`ifdef ASSIST_SEQ_FAULT_COUNT_EN
    chk("t6_fault_count0", int'(fcount), 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    // randomized phase, checked cycle-by-cycle against the model
    for (int c = 0; c < 4000; c++) begin
      r = $urandom_range(0, 99);
      if (r < 2) enable = ~enable;
      brake = (r >= 2 && r < 4);
      if (r >= 4 && r < 8) req = 13'($urandom_range(0, 8191));
      else if (r >= 8 && r < 12) req = 13'($urandom_range(0, 300));
      if (r >= 12 && r < 14) begin
        v = int'($urandom_range(0, 1023)) - 512; set_roll(v);
      end else if (r >= 14 && r < 30) begin
        v = int'($urandom_range(0, 88)) - 44; set_roll(v);
      end
      if (r == 30) cad_run = ~cad_run;
      if (r == 31) cad_per = int'($urandom_range(4, 40));
      if (r == 32) set_roll(ROLL_LIM);
      if (r == 33) set_roll(-(ROLL_LIM - 1));
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
